// File: rtl/gpio_bank.sv
// gpio_bank: memory-mapped GPIO peripheral with per-pin direction, atomic
// set/clear, a configurable-depth input synchroniser and edge-detect
// interrupts with write-1-to-clear status. Reads are combinational.
module gpio_bank #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sel,
    input  logic                  we,
    input  logic [2:0]            addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    input  logic [WIDTH-1:0]      port_in,
    output logic [WIDTH-1:0]      port_out,
    output logic [WIDTH-1:0]      port_oe,
    output logic                  irq
);

    localparam logic [2:0] A_OUT  = 3'd0;
    localparam logic [2:0] A_DIR  = 3'd1;
    localparam logic [2:0] A_IN   = 3'd2;
    localparam logic [2:0] A_IE   = 3'd3;
    localparam logic [2:0] A_EDGE = 3'd4;
    localparam logic [2:0] A_STAT = 3'd5;
    localparam logic [2:0] A_SET  = 3'd6;
    localparam logic [2:0] A_CLR  = 3'd7;

    logic [WIDTH-1:0] out_r;
    logic [WIDTH-1:0] dir_r;
    logic [WIDTH-1:0] ie_r;
    logic [WIDTH-1:0] edge_r;
    logic [WIDTH-1:0] stat_r;
    logic [WIDTH-1:0] prev_r;
    logic [WIDTH-1:0] sync_r [SYNC_STAGES];

    logic             wr_en;
    logic [WIDTH-1:0] wval;
    logic [WIDTH-1:0] pin_val;
    logic [WIDTH-1:0] in_val;
    logic [WIDTH-1:0] evt;
    logic [WIDTH-1:0] w1c_mask;
    logic             unused_wdata;

    assign wr_en    = sel & we;
    // Only the low WIDTH bits of the bus carry pin data.
    assign wval     = wdata[WIDTH-1:0];
    assign unused_wdata = ^wdata;

    // A pin configured as output sees its own driven level at the pad.
    assign pin_val  = (dir_r & out_r) | (~dir_r & port_in);
    assign in_val   = sync_r[SYNC_STAGES-1];
    assign evt      = (~edge_r & in_val & ~prev_r) | (edge_r & ~in_val & prev_r);
    assign w1c_mask = (wr_en && addr == A_STAT) ? wval : '0;

    assign port_out = out_r;
    assign port_oe  = dir_r;
    assign irq      = |(stat_r & ie_r);

    // Control register writes from the bus, including atomic set/clear of OUT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_r  <= '0;
            dir_r  <= '0;
            ie_r   <= '0;
            edge_r <= '0;
        end else if (wr_en) begin
            case (addr)
                A_OUT:   out_r  <= wval;
                A_DIR:   dir_r  <= wval;
                A_IE:    ie_r   <= wval;
                A_EDGE:  edge_r <= wval;
                A_SET:   out_r  <= out_r | wval;
                A_CLR:   out_r  <= out_r & ~wval;
                default: ;
            endcase
        end
    end

    // Status: write-1-to-clear, but a new event in the same cycle wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_r <= '0;
        end else begin
            stat_r <= (stat_r & ~w1c_mask) | evt;
        end
    end

    // Input synchroniser chain plus the previous-value flop for edge detect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_r[i] <= '0;
            end
            prev_r <= '0;
        end else begin
            sync_r[0] <= pin_val;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
            prev_r <= in_val;
        end
    end

    // Combinational read mux, zero-extended; deselected or write-only reads 0.
    always_comb begin
        rdata = '0;
        if (sel) begin
            case (addr)
                A_OUT:   rdata[WIDTH-1:0] = out_r;
                A_DIR:   rdata[WIDTH-1:0] = dir_r;
                A_IN:    rdata[WIDTH-1:0] = in_val;
                A_IE:    rdata[WIDTH-1:0] = ie_r;
                A_EDGE:  rdata[WIDTH-1:0] = edge_r;
                A_STAT:  rdata[WIDTH-1:0] = stat_r;
                default: rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_gpio_bank.sv
// Directed bench for gpio_bank: three instances (8 pins/2 stages,
// 8 pins/3 stages, 32 pins/2 stages) sharing clock, reset and bus lines.
module tb_gpio_bank;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel_a = 1'b0, sel_b = 1'b0, sel_c = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  addr = 3'd0;
    logic [31:0] wdata = 32'd0;
    logic [7:0]  pin_ab = 8'h00;
    logic [31:0] pin_c = 32'h0;

    logic [31:0] rdata_a, rdata_b, rdata_c;
    logic [7:0]  pout_a, poe_a, pout_b, poe_b;
    logic [31:0] pout_c, poe_c;
    logic        irq_a, irq_b, irq_c;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    gpio_bank #(.WIDTH(8), .SYNC_STAGES(2), .DATA_WIDTH(32)) dut_a (
        .clk(clk), .rst(rst), .sel(sel_a), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata_a), .port_in(pin_ab), .port_out(pout_a), .port_oe(poe_a), .irq(irq_a));

    gpio_bank #(.WIDTH(8), .SYNC_STAGES(3), .DATA_WIDTH(32)) dut_b (
        .clk(clk), .rst(rst), .sel(sel_b), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata_b), .port_in(pin_ab), .port_out(pout_b), .port_oe(poe_b), .irq(irq_b));

    gpio_bank #(.WIDTH(32), .SYNC_STAGES(2), .DATA_WIDTH(32)) dut_c (
        .clk(clk), .rst(rst), .sel(sel_c), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata_c), .port_in(pin_c), .port_out(pout_c), .port_oe(poe_c), .irq(irq_c));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // which: 0 = dut_a, 1 = dut_b, 2 = dut_c
    task automatic wr(input int which, input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        sel_a = (which == 0);
        sel_b = (which == 1);
        sel_c = (which == 2);
        we    = 1'b1;
        addr  = a;
        wdata = d;
        @(posedge clk);
        #1;
        we    = 1'b0;
        sel_a = 1'b0;
        sel_b = 1'b0;
        sel_c = 1'b0;
    endtask

    task automatic rd(input string tag, input int which, input logic [2:0] a,
                      input logic [31:0] exp);
        logic [31:0] v;
        sel_a = (which == 0);
        sel_b = (which == 1);
        sel_c = (which == 2);
        we    = 1'b0;
        addr  = a;
        #1;
        v = (which == 0) ? rdata_a : (which == 1) ? rdata_b : rdata_c;
        chk(tag, v, exp);
        sel_a = 1'b0;
        sel_b = 1'b0;
        sel_c = 1'b0;
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // Power-on reset
        edges(2);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("por_port_out", {24'h0, pout_a}, 32'h0);
        chk("por_irq", {31'h0, irq_a}, 32'h0);

        // Asynchronous reset mid-cycle
        wr(0, 3'd0, 32'hA5);
        wr(0, 3'd1, 32'hFF);
        chk("pre_rst_out", {24'h0, pout_a}, 32'hA5);
        chk("pre_rst_oe", {24'h0, poe_a}, 32'hFF);
        edges(3);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_port_out", {24'h0, pout_a}, 32'h0);
        chk("rst_port_oe", {24'h0, poe_a}, 32'h0);
        chk("rst_irq", {31'h0, irq_a}, 32'h0);
        rd("rst_rd0", 0, 3'd0, 32'h0);
        rd("rst_rd1", 0, 3'd1, 32'h0);
        rd("rst_rd3", 0, 3'd3, 32'h0);
        rd("rst_rd4", 0, 3'd4, 32'h0);
        rd("rst_rd5", 0, 3'd5, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        edges(4);
        rd("post_rst_stat", 0, 3'd5, 32'h0);

        // Write / SET / CLR
        wr(0, 3'd0, 32'h0F);
        chk("out_wr", {24'h0, pout_a}, 32'h0F);
        wr(0, 3'd6, 32'hF0);
        chk("out_set", {24'h0, pout_a}, 32'hFF);
        wr(0, 3'd7, 32'h81);
        chk("out_clr", {24'h0, pout_a}, 32'h7E);
        rd("rd_out", 0, 3'd0, 32'h0000007E);
        rd("rd_set_addr", 0, 3'd6, 32'h0);
        rd("rd_clr_addr", 0, 3'd7, 32'h0);
        wr(0, 3'd0, 32'hFFFFFF00);
        rd("rd_out_upper", 0, 3'd0, 32'h0);
        wr(0, 3'd1, 32'h3C);
        chk("oe_wr", {24'h0, poe_a}, 32'h3C);
        rd("rd_dir", 0, 3'd1, 32'h3C);
        wr(0, 3'd1, 32'h00);
        wr(0, 3'd2, 32'hFF);
        rd("rd_in_ro", 0, 3'd2, 32'h0);
        edges(4);
        rd("stat_quiet", 0, 3'd5, 32'h0);

        // Synchroniser latency: 2 stages on dut_a, 3 on dut_b
        @(negedge clk);
        pin_ab = 8'h3C;
        edges(1);
        rd("sync_a_e1", 0, 3'd2, 32'h00);
        rd("sync_b_e1", 1, 3'd2, 32'h00);
        edges(1);
        rd("sync_a_e2", 0, 3'd2, 32'h3C);
        rd("sync_b_e2", 1, 3'd2, 32'h00);
        rd("stat_a_e2", 0, 3'd5, 32'h00);
        edges(1);
        rd("sync_b_e3", 1, 3'd2, 32'h3C);
        rd("stat_a_e3", 0, 3'd5, 32'h3C);
        chk("irq_masked", {31'h0, irq_a}, 32'h0);
        wr(0, 3'd5, 32'h3C);
        rd("stat_w1c_all", 0, 3'd5, 32'h00);

        // Rising-edge interrupt on pin0
        wr(0, 3'd3, 32'h01);
        wr(0, 3'd4, 32'h00);
        @(negedge clk);
        pin_ab = 8'h3D;
        edges(2);
        rd("rise_e2_stat", 0, 3'd5, 32'h00);
        chk("rise_e2_irq", {31'h0, irq_a}, 32'h0);
        edges(1);
        rd("rise_e3_stat", 0, 3'd5, 32'h01);
        chk("rise_e3_irq", {31'h0, irq_a}, 32'h1);
        wr(0, 3'd5, 32'h01);
        rd("rise_w1c_stat", 0, 3'd5, 32'h00);
        chk("rise_w1c_irq", {31'h0, irq_a}, 32'h0);
        @(negedge clk);
        pin_ab = 8'h3C;
        edges(4);
        rd("rise_fall_none", 0, 3'd5, 32'h00);

        // Falling, masked, then unmasked
        wr(0, 3'd3, 32'h00);
        wr(0, 3'd4, 32'h02);
        @(negedge clk);
        pin_ab = 8'h3E;
        edges(4);
        rd("fall_rise_none", 0, 3'd5, 32'h00);
        @(negedge clk);
        pin_ab = 8'h3C;
        edges(3);
        rd("fall_stat", 0, 3'd5, 32'h02);
        chk("fall_irq_masked", {31'h0, irq_a}, 32'h0);
        wr(0, 3'd3, 32'h02);
        chk("fall_irq_unmask", {31'h0, irq_a}, 32'h1);

        // W1C coincident with a new falling event: set wins
        @(negedge clk);
        pin_ab = 8'h3E;
        edges(4);
        @(negedge clk);
        pin_ab = 8'h3C;
        @(posedge clk);
        @(posedge clk);
        wr(0, 3'd5, 32'h02);
        rd("w1c_vs_set", 0, 3'd5, 32'h02);
        chk("w1c_vs_set_irq", {31'h0, irq_a}, 32'h1);
        wr(0, 3'd5, 32'h02);
        rd("w1c_plain", 0, 3'd5, 32'h00);
        chk("w1c_plain_irq", {31'h0, irq_a}, 32'h0);

        // Bus select gating
        wr(0, 3'd0, 32'h55);
        @(negedge clk);
        sel_a = 1'b0;
        we    = 1'b1;
        addr  = 3'd0;
        wdata = 32'hFF;
        #1;
        chk("nosel_rdata", rdata_a, 32'h0);
        @(posedge clk);
        #1;
        we = 1'b0;
        chk("nosel_out", {24'h0, pout_a}, 32'h55);
        rd("nosel_rd", 0, 3'd0, 32'h55);

        // Full-width instance
        wr(2, 3'd0, 32'hDEADBEEF);
        rd("w32_rd", 2, 3'd0, 32'hDEADBEEF);
        chk("w32_port_out", pout_c, 32'hDEADBEEF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/gpio_bank.md
Name: gpio_bank

Overview:
Parametrised memory-mapped GPIO peripheral and successor to the fixed 8-bit in/out port pair. Adds:
- per-pin direction control
- atomic set/clear writes
- a configurable-depth input synchroniser
- per-pin edge-detect interrupts with write-1-to-clear status

Sits on the single-cycle core's data-memory bus beside the RAM and is selected by the address decoder. Reads are combinational so a load completes in one cycle.

Parameters:
WIDTH, 8, number of pins (legal 1..32)
SYNC_STAGES, 2, input synchroniser flops per pin (legal 2..4)
DATA_WIDTH, 32, bus data width

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
sel  input  1  block selected by address decoder
we  input  1  write strobe, qualified by sel
addr  input  3  word offset of register
wdata  input  DATA_WIDTH  write data
rdata  output  DATA_WIDTH  read data, combinational
port_in  input  WIDTH  asynchronous external pins
port_out  output  WIDTH  output pin values
port_oe  output  WIDTH  per-pin output enable, 1 = drive
irq  output  1  level interrupt to core

Behaviour:
- Register map (addr):
  - 0 OUT: rw
  - 1 DIR: rw, 1 = output
  - 2 IN: ro, synchronised pins
  - 3 IE: rw, interrupt enable
  - 4 EDGE: rw, 0 = rising, 1 = falling
  - 5 STAT: read status, write-1-to-clear
  - 6 SET: wo, OUT |= wdata
  - 7 CLR: wo, OUT &= ~wdata
- Write occurs at the clk rising edge when sel & we. Only wdata[WIDTH-1:0] is used; upper bits are ignored. Writes to addr 2 have no effect.
- rdata = 0 when sel = 0. Otherwise it is the zero-extended register value. Addresses 6 and 7 read 0.
- port_out = OUT; port_oe = DIR. Both update one edge after the write.
- Synchroniser: SYNC_STAGES flops per pin; IN = last stage. A pin change becomes visible in IN after SYNC_STAGES edges.
- One extra flop (prev) holds the previous IN. Event per pin is IN & ~prev (rising) or ~IN & prev (falling), chosen by EDGE.
- STAT bit is set at the edge following the event, i.e. SYNC_STAGES+1 edges after the pin change. It is set regardless of IE.
- irq = |(STAT & IE), combinational from registers, so there is no further delay.
- Event detection also runs on pins with DIR = 1; these read back their own driven level.
- Simultaneous W1C and a new event on the same bit: set wins, bit stays 1.
- A write to IE or EDGE takes effect for events evaluated from the next cycle.
- Reset (async, any time) clears, combinationally:
  - OUT, DIR, IE, EDGE, STAT
  - all synchroniser flops and prev
  - port_out = 0, port_oe = 0, irq = 0
  - an in-flight synchroniser value is discarded.
- After reset release, a pin already high produces one rising event (chain starts at 0). This sets STAT only; irq stays low because IE = 0.
- SET and CLR of the same bit in one cycle cannot occur, since there is a single write port.

Test Plan:
- Reset: assert rst mid-cycle with OUT=0xA5, DIR=0xFF → port_out, port_oe, irq go 0 immediately. Reads of 0, 1, 3, 4, 5 all return 0.
- Write/SET/CLR:
  - write OUT=0x0F → port_out=0x0F next edge
  - SET 0xF0 → 0xFF
  - CLR 0x81 → 0x7E
  - read addr 0 = 0x0000007E
  - write 0xFFFFFF00 to OUT → reads 0x00000000 (upper bits ignored).
- Synchroniser latency: port_in 0x00→0x3C at edge 0 → IN reads 0x3C after edge 2 (SYNC_STAGES=2), not before. Repeat with SYNC_STAGES=3 → after edge 3.
- Rising interrupt: IE=0x01, EDGE=0, pin0 0→1 → STAT=0x01 and irq=1 after edge 3. Write STAT=0x01 → STAT=0, irq=0. Pin0 1→0 → no event.
- Falling, masked and clear-vs-set:
  - EDGE=0x02, IE=0, pin1 1→0 → STAT=0x02, irq=0; then IE=0x02 → irq=1 same cycle.
  - W1C of bit1 coincident with a new falling event on pin1 → STAT bit1 remains 1.
- Bus select: sel=0 with we=1 and addr=0 → OUT unchanged, rdata=0. WIDTH=32 instance: OUT=0xDEADBEEF reads back exactly.
